// File: rtl/fifo_pkg.sv
// Shared FIFO constants and types, used by the FIFO controller and its register-file/display responder.
package fifo_pkg;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = 3;
    localparam int FIFO_DW    = 4;

    typedef logic [FIFO_AW-1:0] fifo_addr_t;
    typedef logic [FIFO_DW-1:0] fifo_data_t;
endpackage

// File: rtl/fifo_rf_display_scan_prescaler.sv
// Digit-scan prescaler: div_cnt counts 0..DIV-1 and tick marks the last count of each period.
module scan_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt;

    // With DIV=1 the counter is pinned at 0, so tick is high every cycle.
    assign tick = (div_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end
endmodule

// File: rtl/fifo_rf_display.sv
// FIFO register-file storage with a scanned 8-digit hex display of all entries.
// Build option: define RF_WRITE_FORWARD_EN to bypass same-cycle write data onto rd.
module fifo_rf_display
    import fifo_pkg::*;
#(
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AW       = FIFO_AW,
    parameter int DW       = FIFO_DW,
    parameter int SCAN_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra,
    output logic [DW-1:0]    rd,
    input  logic [AW-1:0]    wa,
    input  logic [DW-1:0]    wd,
    input  logic             we,
    input  logic [DEPTH-1:0] valid,
    output logic [DEPTH-1:0] an_n,
    output logic [DW-1:0]    seg_hex,
    output logic             dp_n
);
    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    scan_idx;
    logic             tick;
    logic [DEPTH-1:0] an_n_p0;
    logic [DW-1:0]    seg_hex_p0;
    logic             dp_n_p0;

    function automatic logic [DEPTH-1:0] digit_onehot(input logic [AW-1:0] idx);
        logic [DEPTH-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

    // Reset wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

`ifdef RF_WRITE_FORWARD_EN
    assign rd = (we && !rst && (wa == ra)) ? wd : mem[ra];
`else
    assign rd = mem[ra];
`endif

    scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // DEPTH == 2**AW, so the natural overflow gives the DEPTH-1 -> 0 wrap.
    always_ff @(posedge clk) begin
        if (rst)
            scan_idx <= '0;
        else if (tick)
            scan_idx <= scan_idx + 1'b1;
    end

    // p0: digit decode from the current scan position
    always_comb begin
        an_n_p0    = valid[scan_idx] ? ~digit_onehot(scan_idx) : '1;
        seg_hex_p0 = mem[scan_idx];
        dp_n_p0    = ~(valid[scan_idx] && (scan_idx == ra));
    end

    // p1: registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            an_n    <= '1;
            seg_hex <= '0;
            dp_n    <= 1'b1;
        end else begin
            an_n    <= an_n_p0;
            seg_hex <= seg_hex_p0;
            dp_n    <= dp_n_p0;
        end
    end
endmodule

// File: tb/tb_fifo_rf_display.sv
// Self-checking bench for fifo_rf_display: a cycle model queues expected display outputs per edge.
module tb_fifo_rf_display;
    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       rst;
    logic [2:0] ra;
    logic [3:0] rd;
    logic [2:0] wa;
    logic [3:0] wd;
    logic       we;
    logic [7:0] valid;
    logic [7:0] an_n;
    logic [3:0] seg_hex;
    logic       dp_n;

    typedef struct {
        logic [7:0] an;
        logic [3:0] seg;
        logic       dp;
    } exp_t;

    exp_t       q[$];
    logic [3:0] m_mem [8];
    int         m_div;
    int         m_idx;
    int         n_cmp;
    int         n_fail;

    fifo_rf_display #(
        .DEPTH(8), .AW(3), .DW(4), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ra      (ra),
        .rd      (rd),
        .wa      (wa),
        .wd      (wd),
        .we      (we),
        .valid   (valid),
        .an_n    (an_n),
        .seg_hex (seg_hex),
        .dp_n    (dp_n)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Predict the outputs this edge produces, advance the model, then step past the edge.
    task automatic clk_cycle();
        exp_t e;
        if (rst) begin
            e.an  = 8'hFF;
            e.seg = 4'h0;
            e.dp  = 1'b1;
        end else begin
            e.an  = valid[m_idx] ? ~(8'd1 << m_idx) : 8'hFF;
            e.seg = m_mem[m_idx];
            e.dp  = ~(valid[m_idx] && (m_idx == int'(ra)));
        end
        q.push_back(e);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
            m_div = 0;
            m_idx = 0;
        end else begin
            if (we) m_mem[wa] = wd;
            if (m_div == SCAN_DIV - 1) begin
                m_div = 0;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_div++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; we = 1'b0; wa = 3'd0; wd = 4'h0; ra = 3'd0; valid = 8'h00;
        clk_cycle();
        e = q.pop_front();
        n_cmp++;
        if ({an_n, seg_hex, dp_n} !== {e.an, e.seg, e.dp} || {an_n, seg_hex, dp_n} !== {8'hFF, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: an_n=%h seg_hex=%h dp_n=%b, required an_n=ff seg_hex=0 dp_n=1", an_n, seg_hex, dp_n);
        end
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            ra = 3'(a);
            #1;
            n_cmp++;
            if (rd !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_rd[%0d]: rd=%h, required 0", a, rd);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        we = 1'b1; wa = 3'd3; wd = 4'hA;
        clk_cycle();
        e = q.pop_front();
        n_cmp++;
        if ({an_n, seg_hex, dp_n} !== {e.an, e.seg, e.dp}) begin
            n_fail++;
            $display("FAIL write_read_display: got %h/%h/%b, required %h/%h/%b", an_n, seg_hex, dp_n, e.an, e.seg, e.dp);
        end
        we = 1'b0; ra = 3'd3;
        #1;
        n_cmp++;
        if (rd !== 4'hA) begin
            n_fail++;
            $display("FAIL write_read_ra3: rd=%h, required a", rd);
        end
        ra = 3'd4;
        #1;
        n_cmp++;
        if (rd !== 4'h0) begin
            n_fail++;
            $display("FAIL write_read_ra4: rd=%h, required 0", rd);
        end
    endtask

    task automatic test_bypass();
        logic [3:0] want;
        we = 1'b1; wa = 3'd5; wd = 4'h2;
        clk_cycle();
        void'(q.pop_front());
        ra = 3'd5; we = 1'b1; wa = 3'd5; wd = 4'h7;
        #1;
`ifdef RF_WRITE_FORWARD_EN
        want = 4'h7;
`else
        want = 4'h2;
`endif
        n_cmp++;
        if (rd !== want) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: rd=%h, required %h", rd, want);
        end
        clk_cycle();
        void'(q.pop_front());
        we = 1'b0;
        #1;
        n_cmp++;
        if (rd !== 4'h7) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: rd=%h, required 7", rd);
        end
    endtask

    task automatic test_scan_blanking();
        exp_t       e;
        logic [7:0] an_req;
        int         idx;
        valid = 8'b0000_0101; ra = 3'd7; we = 1'b0; rst = 1'b1;
        clk_cycle();
        void'(q.pop_front());
        rst = 1'b0;
        for (int k = 0; k < 36; k++) begin
            clk_cycle();
            e   = q.pop_front();
            idx = (k / SCAN_DIV) % 8;
            an_req = (idx == 0) ? 8'hFE : (idx == 2) ? 8'hFB : 8'hFF;
            n_cmp++;
            if (an_n !== an_req || {an_n, seg_hex, dp_n} !== {e.an, e.seg, e.dp}) begin
                n_fail++;
                $display("FAIL scan_blank cycle %0d: got %h/%h/%b, required an_n=%h model %h/%h/%b",
                         k, an_n, seg_hex, dp_n, an_req, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_empty();
        exp_t e;
        valid = 8'h00; ra = 3'd0; we = 1'b0; rst = 1'b1;
        clk_cycle();
        void'(q.pop_front());
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            clk_cycle();
            e = q.pop_front();
            n_cmp++;
            if (an_n !== 8'hFF || dp_n !== 1'b1 || seg_hex !== e.seg) begin
                n_fail++;
                $display("FAIL empty cycle %0d: an_n=%h dp_n=%b seg=%h, required ff/1/%h", k, an_n, dp_n, seg_hex, e.seg);
            end
        end
    endtask

    task automatic test_head_marker();
        exp_t       e;
        logic [7:0] an_req;
        logic       dp_req;
        int         idx;
        valid = 8'hFF; ra = 3'd2; we = 1'b0; rst = 1'b1;
        clk_cycle();
        void'(q.pop_front());
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == 8) begin
                we = 1'b1; wa = 3'd2; wd = 4'hC;
            end
            clk_cycle();
            we  = 1'b0;
            e   = q.pop_front();
            idx = (k / SCAN_DIV) % 8;
            an_req = ~(8'd1 << idx);
            dp_req = (idx == 2) ? 1'b0 : 1'b1;
            n_cmp++;
            if (an_n !== an_req || dp_n !== dp_req || {an_n, seg_hex, dp_n} !== {e.an, e.seg, e.dp}) begin
                n_fail++;
                $display("FAIL head_marker cycle %0d: got %h/%h/%b, required an_n=%h dp_n=%b seg=%h",
                         k, an_n, seg_hex, dp_n, an_req, dp_req, e.seg);
            end
            if (k >= 9 && k <= 11) begin
                n_cmp++;
                if (seg_hex !== 4'hC) begin
                    n_fail++;
                    $display("FAIL head_seg cycle %0d: seg_hex=%h, required c", k, seg_hex);
                end
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        exp_t e;
        valid = 8'hFF; ra = 3'd0; we = 1'b0; rst = 1'b1;
        clk_cycle();
        void'(q.pop_front());
        rst = 1'b0;
        we = 1'b1; wa = 3'd1; wd = 4'h5;
        clk_cycle();
        void'(q.pop_front());
        we = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            clk_cycle();
            e = q.pop_front();
            if (k == 20) begin
                n_cmp++;
                if (an_n !== 8'hDF || {an_n, seg_hex, dp_n} !== {e.an, e.seg, e.dp}) begin
                    n_fail++;
                    $display("FAIL mid_scan_pre: an_n=%h seg=%h, required an_n=df seg=%h", an_n, seg_hex, e.seg);
                end
            end
        end
        rst = 1'b1; we = 1'b1; wa = 3'd1; wd = 4'hF;
        clk_cycle();
        e = q.pop_front();
        n_cmp++;
        if ({an_n, seg_hex, dp_n} !== {8'hFF, 4'h0, 1'b1} || {an_n, seg_hex, dp_n} !== {e.an, e.seg, e.dp}) begin
            n_fail++;
            $display("FAIL mid_scan_reset: got %h/%h/%b, required ff/0/1", an_n, seg_hex, dp_n);
        end
        rst = 1'b0; we = 1'b0; ra = 3'd1;
        #1;
        n_cmp++;
        if (rd !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_scan_write_dropped: rd=%h, required 0", rd);
        end
        clk_cycle();
        e = q.pop_front();
        n_cmp++;
        if (an_n !== 8'hFE || {an_n, seg_hex, dp_n} !== {e.an, e.seg, e.dp}) begin
            n_fail++;
            $display("FAIL mid_scan_restart: an_n=%h, required fe", an_n);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        m_div  = 0;
        m_idx  = 0;
        rst = 1'b1; we = 1'b0; wa = 3'd0; wd = 4'h0; ra = 3'd0; valid = 8'h00;
        test_reset();
        test_write_read();
        test_bypass();
        test_scan_blanking();
        test_empty();
        test_head_marker();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
